// File: rtl/axis_frame_packer_pkg.sv
// Shared constants, FSM state type and beat-count helper for the AXI4-Stream frame packer.
// Optional tkeep output is enabled by defining AXIS_FRAME_PACKER_TKEEP_EN.
package axis_frame_packer_pkg;

  localparam int PACK_WORD_W         = 16;
  localparam int PACK_WORDS_PER_BEAT = 4;
  localparam int PACK_AXIS_DATA_W    = PACK_WORD_W * PACK_WORDS_PER_BEAT;
  localparam int PACK_NUM_WORDS      = 76;
  localparam int PACK_ADDR_W         = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2
  } pack_state_e;

  function automatic int num_beats(input int words, input int per_beat);
    return (words + per_beat - 1) / per_beat;
  endfunction

endpackage

// File: rtl/axis_frame_packer_lane_reg.sv
// Beat assembly register: writes one word lane per capture strobe and presents the packed beat.
// With AXIS_FRAME_PACKER_TKEEP_EN it also tracks which lanes hold real (non-padded) words.
module axis_frame_packer_lane_reg
  import axis_frame_packer_pkg::*;
#(
  parameter int WORD_W = PACK_WORD_W,
  parameter int LANES  = PACK_WORDS_PER_BEAT,
  parameter int LANE_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cap_en,
  input  logic                      cap_valid,
  input  logic [LANE_W-1:0]         cap_lane,
  input  logic [WORD_W-1:0]         rd_data,
  output logic [WORD_W*LANES-1:0]   beat
`ifdef AXIS_FRAME_PACKER_TKEEP_EN
  ,
  output logic [LANES-1:0]          lane_mask
`endif
);

  // Padded lanes are written with zero so a short last beat never leaks stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (cap_en) begin
      beat[int'(cap_lane)*WORD_W +: WORD_W] <= cap_valid ? rd_data : '0;
    end
  end

`ifdef AXIS_FRAME_PACKER_TKEEP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_mask <= '0;
    end else if (cap_en) begin
      lane_mask[cap_lane] <= cap_valid;
    end
  end
`endif

endmodule

// File: rtl/axis_frame_packer.sv
// Reads a frame of words from a synchronous word memory and streams it as packed AXI4-Stream beats.
// Optional m_axis_tkeep port is enabled by defining AXIS_FRAME_PACKER_TKEEP_EN.
module axis_frame_packer
  import axis_frame_packer_pkg::*;
#(
  parameter int WORD_W         = PACK_WORD_W,
  parameter int WORDS_PER_BEAT = PACK_WORDS_PER_BEAT,
  parameter int NUM_WORDS      = PACK_NUM_WORDS,
  parameter int ADDR_W         = PACK_ADDR_W
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               rd_en,
  output logic [ADDR_W-1:0]                  rd_addr,
  input  logic [WORD_W-1:0]                  rd_data,
  output logic [WORD_W*WORDS_PER_BEAT-1:0]   m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast
`ifdef AXIS_FRAME_PACKER_TKEEP_EN
  ,
  output logic [WORD_W*WORDS_PER_BEAT/8-1:0] m_axis_tkeep
`endif
);

  localparam int NUM_BEATS = num_beats(NUM_WORDS, WORDS_PER_BEAT);
  localparam int BEAT_W    = $clog2(NUM_BEATS + 1);
  localparam int LANE_W    = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
  localparam int FILL_W    = $clog2(WORDS_PER_BEAT + 1);
  localparam int CTR_W     = ADDR_W + 1;

  localparam logic [FILL_W-1:0] FILL_LANES  = FILL_W'(WORDS_PER_BEAT);
  localparam logic [CTR_W-1:0]  WORDS_TOTAL = CTR_W'(NUM_WORDS);
  localparam logic [BEAT_W-1:0] BEAT_LAST   = BEAT_W'(NUM_BEATS - 1);

  pack_state_e         state, state_next;
  logic [FILL_W-1:0]   fill_cyc;
  logic [CTR_W-1:0]    word_ctr;
  logic [BEAT_W-1:0]   beat_ctr;
  logic [ADDR_W-1:0]   addr_hold;
  logic                issue_slot;
  logic                handshake;
  logic                last_beat;
  logic                cap_en;
  logic                cap_valid;
  logic [LANE_W-1:0]   cap_lane;
  logic                done_q;

  // One lane slot per FILL cycle; slots past the end of the frame become padding with no read.
  assign issue_slot = (state == FILL) && (fill_cyc < FILL_LANES);
  assign rd_en      = issue_slot && (word_ctr < WORDS_TOTAL);
  assign rd_addr    = rd_en ? word_ctr[ADDR_W-1:0] : addr_hold;
  assign handshake  = (state == SEND) && m_axis_tready;
  assign last_beat  = (beat_ctr == BEAT_LAST);

  assign busy          = (state != IDLE);
  assign done          = done_q;
  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tlast  = (state == SEND) && last_beat;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FILL ends once the last lane's read data has landed, which is the cycle after the final slot.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = FILL;
      FILL: if (fill_cyc == FILL_LANES) state_next = SEND;
      SEND: if (m_axis_tready) state_next = last_beat ? IDLE : FILL;
      default: state_next = IDLE;
    endcase
  end

  // Capture strobes trail the read slots by one cycle to line up with the memory's read latency.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      fill_cyc  <= '0;
      word_ctr  <= '0;
      beat_ctr  <= '0;
      addr_hold <= '0;
      cap_en    <= 1'b0;
      cap_valid <= 1'b0;
      cap_lane  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= handshake && last_beat;
      cap_en    <= issue_slot;
      cap_valid <= rd_en;
      cap_lane  <= fill_cyc[LANE_W-1:0];
      case (state)
        IDLE: begin
          if (start) begin
            fill_cyc <= '0;
            word_ctr <= '0;
            beat_ctr <= '0;
          end
        end
        FILL: begin
          fill_cyc <= fill_cyc + FILL_W'(1);
          if (rd_en) begin
            addr_hold <= word_ctr[ADDR_W-1:0];
            word_ctr  <= word_ctr + CTR_W'(1);
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            fill_cyc <= '0;
            beat_ctr <= beat_ctr + BEAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AXIS_FRAME_PACKER_TKEEP_EN
  localparam int KEEP_PER_WORD = WORD_W / 8;
  logic [WORDS_PER_BEAT-1:0] lane_mask;

  axis_frame_packer_lane_reg #(
    .WORD_W    (WORD_W),
    .LANES     (WORDS_PER_BEAT),
    .LANE_W    (LANE_W)
  ) u_lane_reg (
    .clk       (aclk),
    .rst       (areset),
    .cap_en    (cap_en),
    .cap_valid (cap_valid),
    .cap_lane  (cap_lane),
    .rd_data   (rd_data),
    .beat      (m_axis_tdata),
    .lane_mask (lane_mask)
  );

  always_comb begin
    m_axis_tkeep = '0;
    for (int i = 0; i < WORDS_PER_BEAT; i++) begin
      for (int j = 0; j < KEEP_PER_WORD; j++) begin
        m_axis_tkeep[i*KEEP_PER_WORD + j] = lane_mask[i];
      end
    end
  end
`else
  axis_frame_packer_lane_reg #(
    .WORD_W    (WORD_W),
    .LANES     (WORDS_PER_BEAT),
    .LANE_W    (LANE_W)
  ) u_lane_reg (
    .clk       (aclk),
    .rst       (areset),
    .cap_en    (cap_en),
    .cap_valid (cap_valid),
    .cap_lane  (cap_lane),
    .rd_data   (rd_data),
    .beat      (m_axis_tdata)
  );
`endif

endmodule

// File: tb/tb_axis_frame_packer.sv
// Bench for axis_frame_packer: a full-size instance and a 6-word instance sharing one clock/reset.
// Tracks m_axis_tkeep as well when AXIS_FRAME_PACKER_TKEEP_EN is defined.
module tb_axis_frame_packer;

  localparam int NW_M = 76;
  localparam int NW_P = 6;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [7:0]  keep;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic        tready;
  logic        sel;

  logic        start_m, busy_m, done_m, rd_en_m, tvalid_m, tlast_m;
  logic [6:0]  rd_addr_m;
  logic [15:0] rd_data_m;
  logic [63:0] tdata_m;
  logic        start_p, busy_p, done_p, rd_en_p, tvalid_p, tlast_p;
  logic [2:0]  rd_addr_p;
  logic [15:0] rd_data_p;
  logic [63:0] tdata_p;

  logic        o_busy, o_done, o_rd_en, o_tvalid, o_tlast;
  logic [6:0]  o_rd_addr;
  logic [63:0] o_tdata;

  logic [15:0] mem_m [0:127];
  logic [15:0] mem_p [0:7];
  beat_t       exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] first_data, last_data;

  always #5 aclk = ~aclk;

  assign start_m = start & ~sel;
  assign start_p = start & sel;

  assign o_busy    = sel ? busy_p   : busy_m;
  assign o_done    = sel ? done_p   : done_m;
  assign o_rd_en   = sel ? rd_en_p  : rd_en_m;
  assign o_rd_addr = sel ? {4'b0000, rd_addr_p} : rd_addr_m;
  assign o_tvalid  = sel ? tvalid_p : tvalid_m;
  assign o_tlast   = sel ? tlast_p  : tlast_m;
  assign o_tdata   = sel ? tdata_p  : tdata_m;

`ifdef AXIS_FRAME_PACKER_TKEEP_EN
  logic [7:0] tkeep_m, tkeep_p, o_tkeep;
  assign o_tkeep = sel ? tkeep_p : tkeep_m;
`endif

  axis_frame_packer dut (
    .aclk          (aclk),
    .areset        (areset),
    .start         (start_m),
    .busy          (busy_m),
    .done          (done_m),
    .rd_en         (rd_en_m),
    .rd_addr       (rd_addr_m),
    .rd_data       (rd_data_m),
    .m_axis_tdata  (tdata_m),
    .m_axis_tvalid (tvalid_m),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast_m)
`ifdef AXIS_FRAME_PACKER_TKEEP_EN
    ,
    .m_axis_tkeep  (tkeep_m)
`endif
  );

  axis_frame_packer #(.NUM_WORDS(NW_P), .ADDR_W(3)) dut_pad (
    .aclk          (aclk),
    .areset        (areset),
    .start         (start_p),
    .busy          (busy_p),
    .done          (done_p),
    .rd_en         (rd_en_p),
    .rd_addr       (rd_addr_p),
    .rd_data       (rd_data_p),
    .m_axis_tdata  (tdata_p),
    .m_axis_tvalid (tvalid_p),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast_p)
`ifdef AXIS_FRAME_PACKER_TKEEP_EN
    ,
    .m_axis_tkeep  (tkeep_p)
`endif
  );

  // Synchronous word memories: data appears the cycle after rd_en.
  always @(posedge aclk) begin
    if (rd_en_m) rd_data_m <= mem_m[rd_addr_m];
    if (rd_en_p) rd_data_p <= mem_p[rd_addr_p];
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushFrame(input int n);
    int nb;
    nb = (n + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      beat_t e;
      e = '0;
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = b * 4 + k;
        if (idx < n) begin
          e.data[16*k +: 16] = sel ? mem_p[idx] : mem_m[idx];
          e.keep[2*k +: 2]   = 2'b11;
        end
      end
      e.last = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  // Pulses start (sampled at the next edge) and queues the beats that frame must produce.
  task automatic applyStimulus(input logic use_pad);
    sel   = use_pad;
    start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    pushFrame(use_pad ? NW_P : NW_M);
  endtask

  // Runs from the first FILL cycle until done (or stop_beat is presented), checking every cycle.
  task automatic drainFrame(input int n, input int stall_beat, input int stall_len,
                            input int stop_beat, input bit poke_start,
                            output logic [63:0] fd, output logic [63:0] ld);
    int beats, low_run, stalled;
    bit finished;
    beats = 0; low_run = 0; stalled = 0; finished = 0;
    fd = '0; ld = '0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      tready = 1'b1;
      if (o_tvalid && beats == stall_beat && stalled < stall_len) begin
        tready = 1'b0;
        stalled++;
      end
      if (o_tvalid && beats == stop_beat) tready = 1'b0;
      start = poke_start && (cyc == 30 || cyc == 61);
      if (cyc < 4) begin
        checkOutput("rd_en_window", o_rd_en, cyc < n);
        checkOutput("rd_addr_window", o_rd_addr, cyc);
      end
      if (o_rd_en) checkOutput("rd_addr_in_range", o_rd_addr < n, 1);
      if (o_tvalid) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_beat", o_tvalid, 0);
          finished = 1;
        end else begin
          if (low_run > 0) begin
            checkOutput("valid_gap", low_run, 5);
            low_run = 0;
          end
          checkOutput("tdata", o_tdata, exp_q[0].data);
          checkOutput("tlast", o_tlast, exp_q[0].last);
`ifdef AXIS_FRAME_PACKER_TKEEP_EN
          checkOutput("tkeep", o_tkeep, exp_q[0].keep);
`endif
          checkOutput("rd_en_in_send", o_rd_en, 0);
          checkOutput("busy_in_send", o_busy, 1);
          if (beats == stop_beat) begin
            finished = 1;
          end else if (tready) begin
            if (beats == 0) fd = o_tdata;
            ld = o_tdata;
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end else begin
        low_run++;
      end
      if (o_done && !finished) begin
        checkOutput("busy_at_done", o_busy, 0);
        checkOutput("beats_at_done", beats, (n + 3) / 4);
        checkOutput("queue_empty_at_done", exp_q.size(), 0);
        finished = 1;
      end
      if (!finished) begin
        @(posedge aclk);
        #1;
      end
    end
    start = 1'b0;
    if (!finished) checkOutput("frame_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    sel    = 1'b0;
    start  = 1'b0;
    tready = 1'b1;
    areset = 1'b1;
    rd_data_m = '0;
    rd_data_p = '0;
    for (int i = 0; i < 128; i++) mem_m[i] = 16'(i * 257 + 3);
    mem_m[0] = 16'h0100; mem_m[1] = 16'h0000; mem_m[2] = 16'h0100; mem_m[3] = 16'h0000;
    for (int i = 0; i < 6; i++) mem_p[i] = 16'(i + 1);
    mem_p[6] = 16'hDEAD;
    mem_p[7] = 16'hBEEF;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rst_busy", busy_m, 0);
    checkOutput("rst_done", done_m, 0);
    checkOutput("rst_rd_en", rd_en_m, 0);
    checkOutput("rst_rd_addr", rd_addr_m, 0);
    checkOutput("rst_tvalid", tvalid_m, 0);
    checkOutput("rst_tlast", tlast_m, 0);
    checkOutput("rst_tdata", tdata_m, 0);
`ifdef AXIS_FRAME_PACKER_TKEEP_EN
    checkOutput("rst_tkeep", tkeep_m, 0);
`endif
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // Basic frame with tready held high
    applyStimulus(1'b0);
    drainFrame(NW_M, -1, 0, -1, 1'b0, first_data, last_data);
    checkOutput("basic_beat0", first_data, 64'h0000_0100_0000_0100);
    repeat (3) begin
      @(posedge aclk);
      #1;
      checkOutput("post_done_pulse", done_m, 0);
      checkOutput("post_done_busy", busy_m, 0);
    end

    // Backpressure on beat 3 plus start pulses while busy, then a start coincident with done
    applyStimulus(1'b0);
    drainFrame(NW_M, 2, 7, -1, 1'b1, first_data, last_data);
    checkOutput("done_cycle_seen", done_m, 1);
    applyStimulus(1'b0);
    drainFrame(NW_M, -1, 0, -1, 1'b0, first_data, last_data);
    checkOutput("chained_beat0", first_data, 64'h0000_0100_0000_0100);

    // Reset while beat 10 is being presented
    @(posedge aclk);
    #1;
    applyStimulus(1'b0);
    drainFrame(NW_M, -1, 0, 9, 1'b0, first_data, last_data);
    areset = 1'b1;
    #1;
    checkOutput("midrst_tvalid", tvalid_m, 0);
    checkOutput("midrst_busy", busy_m, 0);
    checkOutput("midrst_tdata", tdata_m, 0);
    checkOutput("midrst_rd_en", rd_en_m, 0);
    exp_q.delete();
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    applyStimulus(1'b0);
    drainFrame(NW_M, -1, 0, -1, 1'b0, first_data, last_data);
    checkOutput("after_rst_beat0", first_data, 64'h0000_0100_0000_0100);

    // Padded short frame on the 6-word instance
    @(posedge aclk);
    #1;
    applyStimulus(1'b1);
    drainFrame(NW_P, -1, 0, -1, 1'b0, first_data, last_data);
    checkOutput("pad_beat0", first_data, 64'h0004_0003_0002_0001);
    checkOutput("pad_beat1", last_data, 64'h0000_0000_0006_0005);
    @(posedge aclk);
    #1;
    checkOutput("pad_idle_busy", busy_p, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
